// File: rtl/stadium_pkg.sv
// stadium_pkg: shared FSM state, side encoding and ticket majority classifier.
package stadium_pkg;
   typedef enum logic {OPEN, EVAC} state_t;
   localparam logic SIDE_HOME = 1'b0;
   localparam logic SIDE_AWAY = 1'b1;
   function automatic logic is_home(input logic [31:0] t, input int w);
      int n;
      n = 0;
      for (int i = 0; i < 32; i++) n += int'(t[i]);
      return 2 * n > w;
   endfunction
endpackage

// File: rtl/stadium_gate_ctrl_classifier.sv
// ticket_classifier: combinational home/away decision for one gate's ticket.
module ticket_classifier
   import stadium_pkg::*;
#(
   parameter int TICKET_W = 5
) (
   input  logic [TICKET_W-1:0] ticket_i,
   output logic                side_o
);
   assign side_o = is_home(32'(ticket_i), TICKET_W) ? SIDE_HOME : SIDE_AWAY;
endmodule

// File: rtl/stadium_gate_ctrl.sv
// stadium_gate_ctrl: ordered multi-gate admission chain with per-side occupancy,
// capacity limits, wrong-gate warnings and evacuation FSM.
module stadium_gate_ctrl
   import stadium_pkg::*;
#(
   parameter int         NUM_GATES = 4,
   parameter int         TICKET_W  = 5,
   parameter int         CNT_W     = 8,
   parameter logic [7:0] GATE_SIDE = 8'b1100,
   parameter int         CAP_H     = 200,
   parameter int         CAP_A     = 50
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_GATES-1:0]          valid,
   input  logic [NUM_GATES-1:0]          mode,
   input  logic [NUM_GATES*TICKET_W-1:0] ticketID,
   input  logic                          evac,
   output logic [CNT_W-1:0]              numOfFanInH,
   output logic [CNT_W-1:0]              numOfFanInA,
   output logic [NUM_GATES-1:0]          gateWar,
   output logic [NUM_GATES-1:0]          accept,
   output logic                          fullH,
   output logic                          fullA,
   output logic                          evacuating
);
   localparam logic [CNT_W-1:0] CAP_H_C = CNT_W'(CAP_H);
   localparam logic [CNT_W-1:0] CAP_A_C = CNT_W'(CAP_A);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_t               state_q;
   logic [CNT_W-1:0]     h_q, h_d, a_q, a_d, run, nxt;
   logic [NUM_GATES-1:0] acc_q, acc_d, war_q, war_d, side_w;
   logic                 fh_q, fa_q, away;

   for (genvar g = 0; g < NUM_GATES; g++) begin : g_cls
      ticket_classifier #(.TICKET_W(TICKET_W)) u_cls (
         .ticket_i(ticketID[g*TICKET_W +: TICKET_W]),
         .side_o  (side_w[g])
      );
   end

   // Each gate sees the running count left by lower-indexed gates this cycle.
   always_comb begin
      h_d   = h_q;
      a_d   = a_q;
      acc_d = '0;
      war_d = '0;
      away  = 1'b0;
      run   = '0;
      nxt   = '0;
      for (int g = 0; g < NUM_GATES; g++) begin
         away     = side_w[g];
         run      = away ? a_d : h_d;
         nxt      = mode[g] ? run + ONE : run - ONE;
         war_d[g] = valid[g] && (away != GATE_SIDE[g]);
         acc_d[g] = valid[g] && !war_d[g] &&
                    (mode[g] ? (state_q == OPEN && run < (away ? CAP_A_C : CAP_H_C)) : run != '0);
         if (acc_d[g] && away) a_d = nxt;
         if (acc_d[g] && !away) h_d = nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= OPEN;
         h_q     <= '0;
         a_q     <= '0;
         acc_q   <= '0;
         war_q   <= '0;
         fh_q    <= 1'b0;
         fa_q    <= 1'b0;
      end else begin
         state_q <= state_q == OPEN ? (evac ? EVAC : OPEN)
                                    : ((!evac && h_q == '0 && a_q == '0) ? OPEN : EVAC);
         h_q     <= h_d;
         a_q     <= a_d;
         acc_q   <= acc_d;
         war_q   <= war_d;
         fh_q    <= h_d == CAP_H_C;
         fa_q    <= a_d == CAP_A_C;
      end
   end

   assign numOfFanInH = h_q;
   assign numOfFanInA = a_q;
   assign accept      = acc_q;
   assign gateWar     = war_q;
   assign fullH       = fh_q;
   assign fullA       = fa_q;
   assign evacuating  = state_q == EVAC;
endmodule

// File: tb/tb_stadium_gate_ctrl.sv
// tb_stadium_gate_ctrl: directed vectors; expected responses queued at issue time
// and checked by an independent monitor one cycle later.
module tb_stadium_gate_ctrl;
   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [3:0]  valid = '0, mode = '0;
   logic [19:0] ticketID = '0;
   logic        evac = 1'b0;
   logic [7:0]  numOfFanInH, numOfFanInA;
   logic [3:0]  gateWar, accept;
   logic        fullH, fullA, evacuating;

   typedef struct {
      logic [26:0] v;
      string       n;
   } exp_t;
   exp_t q[$];
   int total = 0;
   int bad   = 0;

   localparam logic [4:0] HT = 5'b10110;
   localparam logic [4:0] AT = 5'b00001;

   stadium_gate_ctrl dut (
      .CLK(CLK), .RST(RST), .valid(valid), .mode(mode), .ticketID(ticketID), .evac(evac),
      .numOfFanInH(numOfFanInH), .numOfFanInA(numOfFanInA), .gateWar(gateWar),
      .accept(accept), .fullH(fullH), .fullA(fullA), .evacuating(evacuating)
   );

   always #5 CLK = ~CLK;

   function automatic logic [19:0] tk(input logic [4:0] t0, t1, t2, t3);
      return {t3, t2, t1, t0};
   endfunction

   task automatic step(input string n, input logic r, input logic [3:0] v, m,
                       input logic [19:0] t, input logic e,
                       input logic [7:0] h, a, input logic [3:0] w, ac,
                       input logic fh, fa, ev);
      exp_t x;
      @(negedge CLK);
      RST = r; valid = v; mode = m; ticketID = t; evac = e;
      x.v = {h, a, w, ac, fh, fa, ev};
      x.n = n;
      q.push_back(x);
   endtask

   initial begin
      exp_t x;
      logic [26:0] act;
      forever begin
         @(posedge CLK);
         #1;
         if (q.size() != 0) begin
            x = q.pop_front();
            act = {numOfFanInH, numOfFanInA, gateWar, accept, fullH, fullA, evacuating};
            total++;
            if (act !== x.v) begin
               bad++;
               $display("FAIL %s: got H=%0d A=%0d war=%b acc=%b fH=%b fA=%b ev=%b want H=%0d A=%0d war=%b acc=%b fH=%b fA=%b ev=%b",
                        x.n, act[26:19], act[18:11], act[10:7], act[6:3], act[2], act[1], act[0],
                        x.v[26:19], x.v[18:11], x.v[10:7], x.v[6:3], x.v[2], x.v[1], x.v[0]);
            end
         end
      end
   end

   initial begin
      step("reset", 1, 4'hF, 4'hF, tk(HT, HT, AT, AT), 0, 0, 0, 4'b0, 4'b0, 0, 0, 0);
      step("home_entry", 0, 4'b0001, 4'b0001, tk(HT, 0, 0, 0), 0, 1, 0, 4'b0, 4'b0001, 0, 0, 0);
      step("wrong_side", 0, 4'b0001, 4'b0001, tk(5'b10010, 0, 0, 0), 0, 1, 0, 4'b0001, 4'b0, 0, 0, 0);
      step("home_exit", 0, 4'b0010, 4'b0000, tk(0, HT, 0, 0), 0, 0, 0, 4'b0, 4'b0010, 0, 0, 0);
      step("underflow", 0, 4'b0010, 4'b0000, tk(0, HT, 0, 0), 0, 0, 0, 4'b0, 4'b0, 0, 0, 0);
      step("mixed_in_out", 0, 4'b0011, 4'b0001, tk(HT, HT, 0, 0), 0, 0, 0, 4'b0, 4'b0011, 0, 0, 0);
      step("invalid_ignored", 0, 4'b0000, 4'hF, tk(AT, AT, HT, HT), 0, 0, 0, 4'b0, 4'b0, 0, 0, 0);
      for (int i = 1; i <= 24; i++)
         step("fill_away", 0, 4'b1100, 4'b1100, tk(0, 0, AT, AT), 0, 0, 8'(2 * i), 4'b0, 4'b1100, 0, 0, 0);
      step("away_49", 0, 4'b0100, 4'b0100, tk(0, 0, AT, 0), 0, 0, 49, 4'b0, 4'b0100, 0, 0, 0);
      step("cap_race", 0, 4'b1100, 4'b1100, tk(0, 0, AT, AT), 0, 0, 50, 4'b0, 4'b0100, 0, 1, 0);
      step("cap_reject", 0, 4'b1000, 4'b1000, tk(0, 0, 0, AT), 0, 0, 50, 4'b0, 4'b0, 0, 1, 0);
      step("away_wrong", 0, 4'b1000, 4'b1000, tk(0, 0, 0, HT), 0, 0, 50, 4'b1000, 4'b0, 0, 1, 0);
      step("reset2", 1, 4'b0, 4'b0, '0, 0, 0, 0, 4'b0, 4'b0, 0, 0, 0);
      step("h2", 0, 4'b0011, 4'b0011, tk(HT, HT, 0, 0), 0, 2, 0, 4'b0, 4'b0011, 0, 0, 0);
      step("a1", 0, 4'b0100, 4'b0100, tk(0, 0, AT, 0), 0, 2, 1, 4'b0, 4'b0100, 0, 0, 0);
      step("evac_same_cycle", 0, 4'b0001, 4'b0001, tk(HT, 0, 0, 0), 1, 3, 1, 4'b0, 4'b0001, 0, 0, 1);
      step("evac_block_entry", 0, 4'b0001, 4'b0001, tk(HT, 0, 0, 0), 1, 3, 1, 4'b0, 4'b0, 0, 0, 1);
      step("evac_exits", 0, 4'b0111, 4'b0000, tk(HT, HT, AT, 0), 1, 1, 0, 4'b0, 4'b0111, 0, 0, 1);
      step("evac_drain", 0, 4'b0001, 4'b0000, tk(HT, 0, 0, 0), 0, 0, 0, 4'b0, 4'b0001, 0, 0, 1);
      step("evac_release", 0, 4'b0, 4'b0, '0, 0, 0, 0, 4'b0, 4'b0, 0, 0, 0);
      step("h2b", 0, 4'b0011, 4'b0011, tk(HT, HT, 0, 0), 0, 2, 0, 4'b0, 4'b0011, 0, 0, 0);
      step("h4", 0, 4'b0011, 4'b0011, tk(HT, HT, 0, 0), 0, 4, 0, 4'b0, 4'b0011, 0, 0, 0);
      step("h5", 0, 4'b0001, 4'b0001, tk(HT, 0, 0, 0), 0, 5, 0, 4'b0, 4'b0001, 0, 0, 0);
      step("evac_h5", 0, 4'b0, 4'b0, '0, 1, 5, 0, 4'b0, 4'b0, 0, 0, 1);
      step("reset_mid_evac", 1, 4'b0001, 4'b0001, tk(HT, 0, 0, 0), 1, 0, 0, 4'b0, 4'b0, 0, 0, 0);
      step("entry_after_rst", 0, 4'b0001, 4'b0001, tk(HT, 0, 0, 0), 0, 1, 0, 4'b0, 4'b0001, 0, 0, 0);
      step("idle", 0, 4'b0, 4'b0, '0, 0, 1, 0, 4'b0, 4'b0, 0, 0, 0);
      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge CLK);
      #3;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/stadium_gate_ctrl.md
Name: stadium_gate_ctrl

Overview:
Parametrised multi-gate stadium admission controller; next generation of the single-gate home/away fan counter. Each gate presents one fan event per cycle (entry or exit) with a ticket ID. Ticket bit-majority classifies the fan as home or away. Per-side occupancy counters are maintained with capacity limits, wrong-gate warnings and an evacuation mode. Sits between gate turnstile readers and the stadium status display/logging.

Parameters:
NUM_GATES, 4, number of gates sampled in parallel (1..8)
TICKET_W, 5, ticket ID width per gate
CNT_W, 8, occupancy counter width
GATE_SIDE, 4'b1100, bit g = 1 means gate g is an away gate, 0 a home gate
CAP_H, 200, home capacity (< 2**CNT_W)
CAP_A, 50, away capacity (< 2**CNT_W)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  synchronous active-high reset
valid  in  NUM_GATES  bit g: gate g presents an event this cycle
mode  in  NUM_GATES  bit g: 1 = entry, 0 = exit
ticketID  in  NUM_GATES*TICKET_W  gate g ticket at bits [g*TICKET_W +: TICKET_W]
evac  in  1  evacuation request (level)
numOfFanInH  out  CNT_W  home occupancy
numOfFanInA  out  CNT_W  away occupancy
gateWar  out  NUM_GATES  1-cycle pulse: gate g event was wrong-side
accept  out  NUM_GATES  1-cycle pulse: gate g event applied to a counter
fullH, fullA  out  1  level: counter == CAP_H / CAP_A
evacuating  out  1  level: FSM in EVAC

Behaviour:
- Reset: sync, active-high; all outputs 0, FSM = OPEN. RST dominates all other inputs in the same cycle.
- Classification: home iff 2*popcount(ticket) > TICKET_W, else away. TICKET_W=5 gives 3..5 ones = home. For even widths a tie is away.
- Side check: event is wrong-side if ticket class != GATE_SIDE[g]. This applies to entries and exits.
  - Wrong-side events: gateWar[g]=1 next cycle, no count change, accept[g]=0.
- Gate processing order: gates are evaluated in ascending index each cycle against a running per-side count. The first value is the registered count; each accepted event updates the running value seen by later gates.
- Entry accepted iff: FSM=OPEN, correct side, running count < CAP of that side. Otherwise rejected silently (accept=0, gateWar=0 unless wrong-side).
- Exit accepted iff: correct side, running count > 0. Exit at zero is rejected; the counter never wraps below 0.
- Counters never exceed CAP and never wrap, in any mix of simultaneous events.
- Latency: counters, accept, gateWar, fullH/fullA all update on the edge that samples the inputs, so they are visible 1 cycle later. Pulses last exactly one cycle.
- valid[g]=0: mode/ticketID of gate g ignored, no pulses.
- FSM:
  - OPEN -> EVAC when evac=1.
  - EVAC -> OPEN when evac=0 and registered numOfFanInH==0 and numOfFanInA==0.
  - EVAC with evac=0 and non-zero counts stays EVAC until counts drain.
  - In EVAC all entries are rejected; exits are processed normally.
  - evacuating = (state==EVAC).
- evac asserted in the same cycle as entries: those entries are still judged in OPEN (state is registered); EVAC blocks entries from the next cycle.

Decomposition:
- Package stadium_pkg: state enum {OPEN, EVAC}; side constants SIDE_HOME=0, SIDE_AWAY=1; function is_home(ticket) (popcount majority).
- Sub-module ticket_classifier: one instance per gate; TICKET_W-bit ticket in, 1-bit side out, purely combinational.
- The main module holds the ordered admission chain, counters and FSM.

Test Plan:
- Reset: RST=1 with valid=4'hF -> all outputs 0 next cycle, evacuating=0.
- Classification: gate0 (home) entry with ticket 5'b10110 -> numOfFanInH=1, accept=4'b0001. Gate0 entry with 5'b10010 -> gateWar=4'b0001, counts unchanged.
- Capacity race: CAP_A=50, numOfFanInA=49, gates 2 and 3 both enter with 5'b00001 -> gate2 accepted, gate3 rejected. Result numOfFanInA=50, fullA=1, accept=4'b0100.
- Underflow: numOfFanInH=0, gate1 exit with home ticket -> accept=0, gateWar=0, count stays 0. Mixed cycle with gate0 entry and gate1 exit, both home -> count ends at 0 (entry first, then exit).
- Evacuation: H=2, A=1, evac=1 -> next cycle evacuating=1 and entries rejected. Three correct-side exits, then evac=0 -> counts 0, FSM returns to OPEN one cycle after the last exit is registered.
- Reset mid-EVAC with H=5: RST=1 -> counts 0, OPEN, and entries are accepted again the following cycle.
